// File: rtl/register_file_be.sv
// -----------------------------------------------------------------------------
// register_file_be
//   Multi-entry register file with two combinational read ports and one
//   synchronous write port qualified by per-byte enables. Entry 0 can be
//   hardwired to zero, and a write can optionally be forwarded to a read of
//   the same address in the same cycle.
//
// Parameters
//   WIDTH      data width in bits (multiple of 8)
//   DEPTH      number of entries (power of 2, >= 2)
//   ZERO_REG   1: entry 0 reads as zero and discards writes
//   BYPASS     1: a read of the address being written returns the merged value
//   RESET_VAL  value loaded into every entry while reset is low
//
// Ports
//   clk        clock, writes on rising edge
//   reset      asynchronous active-low reset (0 = in reset)
//   wr_en      write request
//   wr_addr    write index
//   wr_data    write data
//   wr_be      byte enables, bit i covers wr_data[8i+7:8i]
//   rd_addr_a  read port A index      rd_data_a  read port A data
//   rd_addr_b  read port B index      rd_data_b  read port B data
//
// Handshake: there is none. A write is accepted unconditionally on every
// rising edge where reset==1 and wr_en==1; reads are pure combinational
// lookups with no request/acknowledge.
// -----------------------------------------------------------------------------
module register_file_be #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 32,
  parameter int               ZERO_REG  = 1,
  parameter int               BYPASS    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [WIDTH/8-1:0]        wr_be,
  input  logic [$clog2(DEPTH)-1:0]  rd_addr_a,
  output logic [WIDTH-1:0]          rd_data_a,
  input  logic [$clog2(DEPTH)-1:0]  rd_addr_b,
  output logic [WIDTH-1:0]          rd_data_b
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  // Elaboration-time parameter sanity checks.
  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("register_file_be: WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("register_file_be: DEPTH must be a power of 2 and >= 2");
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];

  // Byte enables expanded to a bit mask.
  logic [WIDTH-1:0] be_mask;
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < NB; b++) begin
      be_mask[8*b +: 8] = {8{wr_be[b]}};
    end
  end

  // Address 0 is special only when the zero register is enabled.
  logic wr_is_zero;
  assign wr_is_zero = (ZERO_REG != 0) && (wr_addr == '0);

  // Merged value of the entry being written: new bytes where enabled, stored
  // bytes elsewhere. Shared by the storage update and the bypass path so both
  // always agree on what the entry becomes.
  logic [WIDTH-1:0] wr_merged;
  assign wr_merged = (wr_data & be_mask) | (mem[wr_addr] & ~be_mask);

  // A write with no enabled bytes changes nothing, so it is not committed.
  logic wr_commit;
  assign wr_commit = wr_en && !wr_is_zero && (wr_be != '0);

  // Reset wins over a coincident write because it is the first branch and
  // is asynchronous.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (wr_commit) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  // Forwarding requires an active write outside reset to a non-zero entry.
  logic byp_ok;
  assign byp_ok = (BYPASS != 0) && reset && wr_en && !wr_is_zero;

  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  // Priority per port: zero entry, then reset value, then bypass, then storage.
  // The explicit reset-value leg keeps the outputs defined even if storage
  // has not yet been touched by a reset.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem[rd_addr[p]];
      if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
      end else if (!reset) begin
        rd_data[p] = RESET_VAL;
      end else if (byp_ok && (rd_addr[p] == wr_addr)) begin
        rd_data[p] = wr_merged;
      end
    end
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];

endmodule

// File: tb/tb_register_file_be.sv
// -----------------------------------------------------------------------------
// tb_register_file_be
//   Directed bench for register_file_be. Two instances share all inputs:
//   u_dut uses ZERO_REG=1/BYPASS=1, u_dut_nb uses ZERO_REG=0/BYPASS=0, both
//   with RESET_VAL=32'hDEAD_BEEF. Inputs change on the falling edge; outputs
//   are sampled 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_register_file_be;

  localparam int               WIDTH = 32;
  localparam int               DEPTH = 32;
  localparam int               AW    = 5;
  localparam logic [WIDTH-1:0] RV    = 32'hDEAD_BEEF;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [3:0]       wr_be;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_a0, rd_b0, rd_a1, rd_b1;

  register_file_be #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1), .BYPASS(1), .RESET_VAL(RV)
  ) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_a0),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_b0)
  );

  register_file_be #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(0), .BYPASS(0), .RESET_VAL(RV)
  ) u_dut_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_a1),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_b1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance through one rising edge and land on the next falling edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic drive_wr(input logic en, input logic [AW-1:0] addr,
                          input logic [WIDTH-1:0] data, input logic [3:0] be);
    wr_en   = en;
    wr_addr = addr;
    wr_data = data;
    wr_be   = be;
  endtask

  // Full write: present it, pass one edge, then deassert.
  task automatic write(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data,
                       input logic [3:0] be);
    drive_wr(1'b1, addr, data, be);
    next_cycle();
    drive_wr(1'b0, '0, '0, '0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    drive_wr(1'b0, '0, '0, '0);
    rd_addr_a = 5'd5;
    rd_addr_b = 5'd0;

    // 1. Asynchronous reset before any clock edge.
    #3 reset = 1'b0;
    #1;
    check("rst_async_a5",     rd_a0, RV);
    check("rst_async_zero",   rd_b0, 32'h0);
    check("rst_async_nb_a5",  rd_a1, RV);
    check("rst_async_nb_0",   rd_b1, RV);

    // Writes are ignored while reset is held through an edge.
    drive_wr(1'b1, 5'd5, 32'h0000_1234, 4'hF);
    #1;
    check("rst_no_bypass",    rd_a0, RV);
    next_cycle();
    #1;
    check("rst_write_ignored", rd_a0, RV);
    reset = 1'b1;
    drive_wr(1'b0, '0, '0, '0);
    #1;
    check("post_rst_a5",      rd_a0, RV);
    next_cycle();

    // 2. Full write, then wr_en=0 must not change the entry.
    rd_addr_b = 5'd7;
    drive_wr(1'b1, 5'd7, 32'h0000_0058, 4'hF);
    #1;
    check("wr7_bypass_b",     rd_b0, 32'h0000_0058);
    check("wr7_nb_old_b",     rd_b1, RV);
    next_cycle();
    drive_wr(1'b0, 5'd7, 32'h0000_0089, 4'hF);
    #1;
    check("wr7_after_b",      rd_b0, 32'h0000_0058);
    check("wr7_nb_after_b",   rd_b1, 32'h0000_0058);
    next_cycle();
    #1;
    check("wr7_hold_b",       rd_b0, 32'h0000_0058);
    check("wr7_nb_hold_b",    rd_b1, 32'h0000_0058);
    drive_wr(1'b0, '0, '0, '0);

    // 3. Byte-enable merge, then a wr_be==0 no-op.
    write(5'd3, 32'h1122_3344, 4'hF);
    write(5'd3, 32'hAABB_CCDD, 4'b0101);
    rd_addr_a = 5'd3;
    #1;
    check("be_merge_a",       rd_a0, 32'h11BB_33DD);
    check("be_merge_nb_a",    rd_a1, 32'h11BB_33DD);
    next_cycle();
    write(5'd3, 32'hFFFF_FFFF, 4'h0);
    #1;
    check("be_zero_noop",     rd_a0, 32'h11BB_33DD);
    check("be_zero_noop_nb",  rd_a1, 32'h11BB_33DD);
    next_cycle();

    // 4. Bypass on both ports versus no bypass.
    write(5'd9, 32'h0000_0005, 4'hF);
    rd_addr_a = 5'd9;
    rd_addr_b = 5'd9;
    drive_wr(1'b1, 5'd9, 32'h0000_0020, 4'hF);
    #1;
    check("byp_a",            rd_a0, 32'h0000_0020);
    check("byp_b",            rd_b0, 32'h0000_0020);
    check("nobyp_a",          rd_a1, 32'h0000_0005);
    check("nobyp_b",          rd_b1, 32'h0000_0005);
    next_cycle();
    // Partial-byte bypass shows the merge of new and stored bytes.
    drive_wr(1'b1, 5'd9, 32'hAB00_0000, 4'b1000);
    #1;
    check("byp_merge_a",      rd_a0, 32'hAB00_0020);
    check("nobyp_merge_a",    rd_a1, 32'h0000_0020);
    next_cycle();
    drive_wr(1'b0, '0, '0, '0);
    #1;
    check("merge_stored_b",   rd_b0, 32'hAB00_0020);
    check("merge_stored_nb",  rd_b1, 32'hAB00_0020);
    next_cycle();

    // 5. Zero register.
    rd_addr_a = 5'd0;
    drive_wr(1'b1, 5'd0, 32'h0000_0028, 4'hF);
    #1;
    check("zero_before",      rd_a0, 32'h0);
    check("zero_nb_before",   rd_a1, RV);
    next_cycle();
    drive_wr(1'b0, '0, '0, '0);
    #1;
    check("zero_after",       rd_a0, 32'h0);
    check("zero_nb_after",    rd_a1, 32'h0000_0028);
    next_cycle();

    // 6. Reset pulse between edges during a pending write.
    write(5'd4, 32'h0000_0015, 4'hF);
    rd_addr_a = 5'd4;
    #1;
    check("e4_written",       rd_a0, 32'h0000_0015);
    drive_wr(1'b1, 5'd4, 32'h0000_0099, 4'hF);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_a",        rd_a0, RV);
    check("mid_rst_nb_a",     rd_a1, RV);
    next_cycle();
    #1;
    check("mid_rst_no99",     rd_a0, RV);
    check("mid_rst_nb_no99",  rd_a1, RV);
    check("mid_rst_e7",       rd_b0, RV);
    reset = 1'b1;
    drive_wr(1'b1, 5'd4, 32'h0000_0077, 4'hF);
    next_cycle();
    drive_wr(1'b0, '0, '0, '0);
    #1;
    check("post_rst_write",    rd_a0, 32'h0000_0077);
    check("post_rst_write_nb", rd_a1, 32'h0000_0077);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
